reg_csr_machine: RTL



---
 rtl/csr_pkg.sv | 34 +++
 rtl/reg_csr_machine_if.sv | 48 ++++
 rtl/csr_counter64.sv | 31 +++
 rtl/reg_csr_machine.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, bit positions, cause codes.
package csr_pkg;

  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMisa      = 12'h301;
  localparam logic [11:0] CsrMie       = 12'h304;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMtval     = 12'h343;
  localparam logic [11:0] CsrMip       = 12'h344;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrMhartid   = 12'hF14;

  localparam int unsigned MstatusMie  = 3;
  localparam int unsigned MstatusMpie = 7;
  localparam int unsigned MipMsip     = 3;
  localparam int unsigned MipMtip     = 7;
  localparam int unsigned MipMeip     = 11;

  localparam logic [4:0] IrqCodeSw    = 5'd3;
  localparam logic [4:0] IrqCodeTimer = 5'd7;
  localparam logic [4:0] IrqCodeExt   = 5'd11;

  // MXL=1 (32-bit), extension I only.
  localparam logic [31:0] MisaValue  = 32'h4000_0100;
  localparam logic [1:0]  MstatusMpp = 2'b11;
  localparam logic [31:0] MieMask    = 32'h0000_0888;

endpackage

// File: rtl/reg_csr_machine_if.sv
// Request, forwarding, trap and interrupt bundle between the pipeline and reg_csr_machine.
interface reg_csr_machine_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned FWD_CH = 2
);
  logic                     FLUSH;
  logic                     STALL;
  logic                     MMU_WAIT;
  logic                     TRAP_EN;
  logic [XLEN-1:0]          TRAP_CODE;
  logic [XLEN-1:0]          TRAP_PC;
  logic [XLEN-1:0]          TRAP_VAL;
  logic                     MRET_EN;
  logic [XLEN-1:0]          MRET_PC;
  logic [1:0]               TRAP_VEC_MODE;
  logic [XLEN-1:0]          TRAP_VEC_BASE;
  logic                     INT_SW;
  logic                     INT_TIMER;
  logic                     INT_EXT;
  logic                     INT_REQ;
  logic [XLEN-1:0]          INT_CAUSE;
  logic                     INSTRET_EN;
  logic [11:0]              RADDR;
  logic                     RVALID;
  logic [XLEN-1:0]          RDATA;
  logic                     RILLEGAL;
  logic                     WREN;
  logic [11:0]              WADDR;
  logic [XLEN-1:0]          WDATA;
  logic [11:0]              FWD_CSR_ADDR;
  logic [FWD_CH-1:0]        FWD_EN;
  logic [12*FWD_CH-1:0]     FWD_ADDR;
  logic [XLEN*FWD_CH-1:0]   FWD_DATA;

  modport slave (
    input  FLUSH, STALL, MMU_WAIT, TRAP_EN, TRAP_CODE, TRAP_PC, TRAP_VAL, MRET_EN,
           INT_SW, INT_TIMER, INT_EXT, INSTRET_EN, RADDR, WREN, WADDR, WDATA,
           FWD_CSR_ADDR, FWD_EN, FWD_ADDR, FWD_DATA,
    output MRET_PC, TRAP_VEC_MODE, TRAP_VEC_BASE, INT_REQ, INT_CAUSE, RVALID, RDATA, RILLEGAL
  );

  modport master (
    output FLUSH, STALL, MMU_WAIT, TRAP_EN, TRAP_CODE, TRAP_PC, TRAP_VAL, MRET_EN,
           INT_SW, INT_TIMER, INT_EXT, INSTRET_EN, RADDR, WREN, WADDR, WDATA,
           FWD_CSR_ADDR, FWD_EN, FWD_ADDR, FWD_DATA,
    input  MRET_PC, TRAP_VEC_MODE, TRAP_VEC_BASE, INT_REQ, INT_CAUSE, RVALID, RDATA, RILLEGAL
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit counter split into 32-bit halves; a write to either half suppresses that cycle's increment.
module csr_counter64 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [31:0] lo_q, hi_q;
  logic [63:0] inc;

  assign inc   = {hi_q, lo_q} + 64'd1;
  assign value = {hi_q, lo_q};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lo_q <= '0;
      hi_q <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) lo_q <= wdata;
      if (wr_hi) hi_q <= wdata;
    end else if (inc_en) begin
      lo_q <= inc[31:0];
      hi_q <= inc[63:32];
    end
  end

endmodule

// File: rtl/reg_csr_machine.sv
// Machine-mode CSR file with captured read path, forwarding, trap/mret and interrupt request.
// Counters are built only when CSR_COUNTERS_EN is defined.
module reg_csr_machine
  import csr_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned FWD_CH  = 2,
  parameter int unsigned HART_ID = 0
) (
  input logic              CLK,
  input logic              RST,
  reg_csr_machine_if.slave bus
);

  // Capture stage
  logic [11:0]                  raddr_q, waddr_q, fwd_csr_addr_q;
  logic [XLEN-1:0]              wdata_q;
  logic                         wren_q;
  logic [FWD_CH-1:0]            fwd_en_q;
  logic [FWD_CH-1:0][11:0]      fwd_addr_q;
  logic [FWD_CH-1:0][XLEN-1:0]  fwd_data_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      raddr_q <= '0; waddr_q <= '0; wdata_q <= '0; wren_q <= 1'b0; fwd_csr_addr_q <= '0;
      fwd_en_q <= '0; fwd_addr_q <= '0; fwd_data_q <= '0;
    end else if (bus.FLUSH) begin
      raddr_q <= '0; waddr_q <= '0; wdata_q <= '0; wren_q <= 1'b0; fwd_csr_addr_q <= '0;
      fwd_en_q <= '0; fwd_addr_q <= '0; fwd_data_q <= '0;
    end else if (!bus.MMU_WAIT) begin
      fwd_en_q   <= bus.FWD_EN;
      fwd_addr_q <= bus.FWD_ADDR;
      fwd_data_q <= bus.FWD_DATA;
      if (bus.STALL) begin
        fwd_csr_addr_q <= '0;
      end else begin
        raddr_q        <= bus.RADDR;
        waddr_q        <= bus.WADDR;
        wdata_q        <= bus.WDATA;
        wren_q         <= bus.WREN;
        fwd_csr_addr_q <= bus.FWD_CSR_ADDR;
      end
    end
  end

  // Architectural state
  logic            mie_bit_q, mpie_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic            wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;

  assign wr_mstatus  = bus.WREN && (bus.WADDR == CsrMstatus);
  assign wr_mie      = bus.WREN && (bus.WADDR == CsrMie);
  assign wr_mtvec    = bus.WREN && (bus.WADDR == CsrMtvec);
  assign wr_mscratch = bus.WREN && (bus.WADDR == CsrMscratch);
  assign wr_mepc     = bus.WREN && (bus.WADDR == CsrMepc);
  assign wr_mcause   = bus.WREN && (bus.WADDR == CsrMcause);
  assign wr_mtval    = bus.WREN && (bus.WADDR == CsrMtval);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mie_bit_q <= 1'b0; mpie_q <= 1'b0;
      mie_q <= '0; mtvec_q <= '0; mscratch_q <= '0; mepc_q <= '0; mcause_q <= '0; mtval_q <= '0;
    end else begin
      if (bus.TRAP_EN) begin
        mpie_q    <= mie_bit_q;
        mie_bit_q <= 1'b0;
        mepc_q    <= {bus.TRAP_PC[XLEN-1:1], 1'b0};
        mcause_q  <= bus.TRAP_CODE;
        mtval_q   <= bus.TRAP_VAL;
      end else if (bus.MRET_EN) begin
        mie_bit_q <= mpie_q;
        mpie_q    <= 1'b1;
      end else if (wr_mstatus) begin
        mie_bit_q <= bus.WDATA[MstatusMie];
        mpie_q    <= bus.WDATA[MstatusMpie];
      end
      // A trap owns mepc/mcause/mtval this cycle; other CSR writes still land.
      if (!bus.TRAP_EN) begin
        if (wr_mepc)   mepc_q   <= {bus.WDATA[XLEN-1:1], 1'b0};
        if (wr_mcause) mcause_q <= bus.WDATA;
        if (wr_mtval)  mtval_q  <= bus.WDATA;
      end
      if (wr_mie)      mie_q      <= bus.WDATA & MieMask;
      if (wr_mtvec)    mtvec_q    <= {bus.WDATA[XLEN-1:2], bus.WDATA[1] ? 2'b00 : bus.WDATA[1:0]};
      if (wr_mscratch) mscratch_q <= bus.WDATA;
    end
  end

  // Interrupts
  logic [XLEN-1:0] mip_val, pend;
  logic            int_req_q;
  logic [XLEN-1:0] int_cause_q;
  logic [4:0]      irq_code;

  always_comb begin
    mip_val          = '0;
    mip_val[MipMsip] = bus.INT_SW;
    mip_val[MipMtip] = bus.INT_TIMER;
    mip_val[MipMeip] = bus.INT_EXT;
  end

  assign pend     = mip_val & mie_q;
  assign irq_code = pend[MipMeip] ? IrqCodeExt : (pend[MipMsip] ? IrqCodeSw : IrqCodeTimer);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      int_req_q   <= 1'b0;
      int_cause_q <= '0;
    end else begin
      int_req_q   <= mie_bit_q && (|pend);
      int_cause_q <= (mie_bit_q && (|pend)) ? {1'b1, (XLEN-1)'(irq_code)} : '0;
    end
  end

  // Counters
  logic [63:0] mcycle, minstret;
`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .CLK    (CLK),
    .RST    (RST),
    .inc_en (1'b1),
    .wr_lo  (bus.WREN && (bus.WADDR == CsrMcycle)),
    .wr_hi  (bus.WREN && (bus.WADDR == CsrMcycleh)),
    .wdata  (bus.WDATA),
    .value  (mcycle)
  );
  csr_counter64 u_minstret (
    .CLK    (CLK),
    .RST    (RST),
    .inc_en (bus.INSTRET_EN),
    .wr_lo  (bus.WREN && (bus.WADDR == CsrMinstret)),
    .wr_hi  (bus.WREN && (bus.WADDR == CsrMinstreth)),
    .wdata  (bus.WDATA),
    .value  (minstret)
  );
`else
  logic unused_instret;
  assign unused_instret = bus.INSTRET_EN;
  assign mcycle         = '0;
  assign minstret       = '0;
`endif

  // Read path
  logic [XLEN-1:0] mstatus_val, arch_val, fwd_val, rdata;
  logic            impl, fwd_hit, fwd_vld, rvalid, rillegal;

  always_comb begin
    mstatus_val              = '0;
    mstatus_val[12:11]       = MstatusMpp;
    mstatus_val[MstatusMpie] = mpie_q;
    mstatus_val[MstatusMie]  = mie_bit_q;
  end

  always_comb begin
    arch_val = '0;
    impl     = 1'b1;
    case (raddr_q)
      CsrMstatus:   arch_val = mstatus_val;
      CsrMisa:      arch_val = MisaValue;
      CsrMie:       arch_val = mie_q;
      CsrMtvec:     arch_val = mtvec_q;
      CsrMscratch:  arch_val = mscratch_q;
      CsrMepc:      arch_val = mepc_q;
      CsrMcause:    arch_val = mcause_q;
      CsrMtval:     arch_val = mtval_q;
      CsrMip:       arch_val = mip_val;
      CsrMcycle:    arch_val = mcycle[31:0];
      CsrMcycleh:   arch_val = mcycle[63:32];
      CsrMinstret:  arch_val = minstret[31:0];
      CsrMinstreth: arch_val = minstret[63:32];
      CsrMhartid:   arch_val = XLEN'(HART_ID);
      default:      impl     = 1'b0;
    endcase
  end

  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    fwd_vld = 1'b0;
    for (int i = 0; i < FWD_CH; i++) begin
      if (!fwd_hit && (fwd_addr_q[i] == raddr_q)) begin
        fwd_hit = 1'b1;
        fwd_val = fwd_data_q[i];
        fwd_vld = fwd_en_q[i];
      end
    end
  end

  always_comb begin
    rdata    = '0;
    rvalid   = 1'b1;
    rillegal = 1'b0;
    if (raddr_q == '0) begin
      rdata = '0;
    end else if (raddr_q == fwd_csr_addr_q) begin
      rvalid = 1'b0;
    end else if (fwd_hit) begin
      rdata  = fwd_val;
      rvalid = fwd_vld;
    end else if (!impl) begin
      rillegal = 1'b1;
    end else if (wren_q && (waddr_q == raddr_q)) begin
      rdata = wdata_q;
    end else begin
      rdata = arch_val;
    end
  end

  assign bus.RDATA         = rdata;
  assign bus.RVALID        = rvalid;
  assign bus.RILLEGAL      = rillegal;
  assign bus.MRET_PC       = mepc_q;
  assign bus.TRAP_VEC_MODE = mtvec_q[1:0];
  assign bus.TRAP_VEC_BASE = {mtvec_q[XLEN-1:2], 2'b00};
  assign bus.INT_REQ       = int_req_q;
  assign bus.INT_CAUSE     = int_cause_q;

endmodule
